// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline: M/W forwarding or RAW stalling, load-use,
// branch flushes, and a small FSM that holds a multi-cycle op in E for MC_LAT cycles.
//
// state | meaning
// IDLE  | no multi-cycle op held in E
// BUSY  | multi-cycle op held in E, cnt = cycles already spent in E
module hazard_unit_mc #(
   parameter int RA_W   = 5,
   parameter bit FWD_EN = 1'b1,
   parameter int MC_LAT = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [RA_W-1:0] Rs1D,
   input  logic [RA_W-1:0] Rs2D,
   input  logic [RA_W-1:0] Rs1E,
   input  logic [RA_W-1:0] Rs2E,
   input  logic [RA_W-1:0] RdE,
   input  logic [RA_W-1:0] RdM,
   input  logic [RA_W-1:0] RdW,
   input  logic            RegWriteE,
   input  logic            RegWriteM,
   input  logic            RegWriteW,
   input  logic [1:0]      ResultSrcE,
   input  logic            PCSrcE,
   input  logic            McStartE,
   output logic [1:0]      ForwardAE,
   output logic [1:0]      ForwardBE,
   output logic            StallF,
   output logic            StallD,
   output logic            StallE,
   output logic            FlushD,
   output logic            FlushE,
   output logic            FlushM,
   output logic            McBusy
);

   localparam int             CW       = $clog2(MC_LAT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(MC_LAT - 1);
   localparam bit             MC_EN    = (MC_LAT > 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            mc_stall;
   logic [1:0]      fwd_a, fwd_b;
   logic            lw_stall, raw_stall, d_stall;

   function automatic logic [1:0] fwd_pick(input logic [RA_W-1:0] src,
                                           input logic [RA_W-1:0] rd_m, input logic we_m,
                                           input logic [RA_W-1:0] rd_w, input logic we_w);
      if (we_m && (rd_m != '0) && (rd_m == src))      return 2'b10;
      else if (we_w && (rd_w != '0) && (rd_w == src)) return 2'b01;
      else                                            return 2'b00;
   endfunction

   // A W-stage match never stalls: the regfile writes in the first half-cycle.
   function automatic logic raw_hit(input logic [RA_W-1:0] src);
      return (src != '0) && ((RegWriteE && (RdE == src)) || (RegWriteM && (RdM == src)));
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      mc_stall = 1'b0;
      case (state)
         IDLE: begin
            if (McStartE && MC_EN) begin
               mc_stall = 1'b1;
               state_nx = BUSY;
               cnt_nx   = CW'(1);
            end
         end
         BUSY: begin
            // McStartE is ignored here: the same op is still being held.
            if (cnt == CNT_LAST) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               mc_stall = 1'b1;
               cnt_nx   = cnt + CW'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_comb begin
      fwd_a     = fwd_pick(Rs1E, RdM, RegWriteM, RdW, RegWriteW) & {2{FWD_EN}};
      fwd_b     = fwd_pick(Rs2E, RdM, RegWriteM, RdW, RegWriteW) & {2{FWD_EN}};
      lw_stall  = FWD_EN && (ResultSrcE == 2'b01) && (RdE != '0) &&
                  ((RdE == Rs1D) || (RdE == Rs2D));
      raw_stall = !FWD_EN && (raw_hit(Rs1D) || raw_hit(Rs2D));
      d_stall   = lw_stall || raw_stall;
   end

   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      McBusy    = 1'b0;
      if (!reset) begin
         ForwardAE = fwd_a;
         ForwardBE = fwd_b;
         McBusy    = (state == BUSY);
         if (mc_stall) begin
            // Holding the mc op wins: no flush may disturb E or D.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
         end else begin
            StallF = d_stall;
            StallD = d_stall;
            FlushD = PCSrcE;
            FlushE = PCSrcE || d_stall;
         end
      end
   end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: three parameter variants driven in parallel, checked
// against a rule-level reference model with directed scenarios and random stimulus.
module tb_hazard_unit_mc;

   localparam int FWD_P[3] = '{1, 0, 1};
   localparam int LAT_P[3] = '{4, 4, 1};

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic       reg_write_e, reg_write_m, reg_write_w;
   logic [1:0] result_src_e;
   logic       pc_src_e, mc_start_e;

   logic [1:0]  fa[3], fb[3];
   logic        sf[3], sd[3], se[3], fd[3], fe[3], fm[3], busy[3];
   logic [10:0] obs[3];

   int n_cmp = 0;
   int n_bad = 0;
   int rem[3];   // cycles the held mc op still has to spend in E

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      hazard_unit_mc #(.RA_W(5), .FWD_EN(FWD_P[g] != 0), .MC_LAT(LAT_P[g])) u_dut (
         .clk(clk), .reset(reset),
         .Rs1D(rs1_d), .Rs2D(rs2_d), .Rs1E(rs1_e), .Rs2E(rs2_e),
         .RdE(rd_e), .RdM(rd_m), .RdW(rd_w),
         .RegWriteE(reg_write_e), .RegWriteM(reg_write_m), .RegWriteW(reg_write_w),
         .ResultSrcE(result_src_e), .PCSrcE(pc_src_e), .McStartE(mc_start_e),
         .ForwardAE(fa[g]), .ForwardBE(fb[g]),
         .StallF(sf[g]), .StallD(sd[g]), .StallE(se[g]),
         .FlushD(fd[g]), .FlushE(fe[g]), .FlushM(fm[g]), .McBusy(busy[g]));
   end

   always_comb
      for (int i = 0; i < 3; i++)
         obs[i] = {fa[i], fb[i], sf[i], sd[i], se[i], fd[i], fe[i], fm[i], busy[i]};

   task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] src);
      if (reg_write_m && rd_m != 0 && rd_m == src) return 2'b10;
      if (reg_write_w && rd_w != 0 && rd_w == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit ref_raw(input logic [4:0] src);
      return src != 0 && ((reg_write_e && rd_e == src) || (reg_write_m && rd_m == src));
   endfunction

   function automatic logic [10:0] model_out(input int i);
      logic [1:0] a, b;
      bit mc, ds, s_f, s_e, f_d, f_e, f_m;
      if (reset) return '0;
      a  = (FWD_P[i] != 0) ? ref_fwd(rs1_e) : 2'b00;
      b  = (FWD_P[i] != 0) ? ref_fwd(rs2_e) : 2'b00;
      ds = (FWD_P[i] != 0) ? (result_src_e == 2'b01 && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d))
                           : (ref_raw(rs1_d) || ref_raw(rs2_d));
      mc = (rem[i] == 0 && mc_start_e && LAT_P[i] > 1) || rem[i] > 1;
      if (mc) begin
         s_f = 1; s_e = 1; f_d = 0; f_e = 0; f_m = 1;
      end else begin
         s_f = ds; s_e = 0; f_d = pc_src_e; f_e = pc_src_e || ds; f_m = 0;
      end
      return {a, b, s_f, s_f, s_e, f_d, f_e, f_m, rem[i] > 0};
   endfunction

   task automatic sample(input string tag);
      @(negedge clk);
      for (int i = 0; i < 3; i++) check($sformatf("%s/u%0d", tag, i), obs[i], model_out(i));
   endtask

   task automatic advance();
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         if (reset)            rem[i] = 0;
         else if (rem[i] > 0)  rem[i] = rem[i] - 1;
         else if (mc_start_e && LAT_P[i] > 1) rem[i] = LAT_P[i] - 1;
      end
      #1;
   endtask

   task automatic cycle(input string tag);
      sample(tag);
      advance();
   endtask

   task automatic clr();
      reset = 0; rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
      reg_write_e = 0; reg_write_m = 0; reg_write_w = 0; result_src_e = 0;
      pc_src_e = 0; mc_start_e = 0;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) rem[i] = 0;
      clr();
      reset = 1;
      rd_m = 5; reg_write_m = 1; rs1_e = 5; mc_start_e = 1; pc_src_e = 0;
      sample("reset");
      check("reset_all_zero", obs[0], 11'd0);
      advance();
      cycle("reset2");
      clr();

      // Forwarding priority and the x0 exclusion
      rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; rs1_e = 5;
      sample("fwd_m");
      check("fwd_m_const", 11'(fa[0]), 11'd2);
      check("fwd_off_const", 11'(fa[1]), 11'd0);
      advance();
      reg_write_m = 0;
      sample("fwd_w");
      check("fwd_w_const", 11'(fa[0]), 11'd1);
      advance();
      rs1_e = 0; rd_m = 0; reg_write_m = 1; rd_w = 0;
      cycle("fwd_x0");
      clr();

      // Load-use, then clear
      result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
      sample("lw");
      check("lw_const", 11'({sf[0], sd[0], fe[0]}), 11'd7);
      advance();
      result_src_e = 2'b00;
      sample("lw_clear");
      check("lw_clear_const", obs[0], 11'd0);
      advance();
      clr();

      // Two back-to-back multi-cycle ops, McStartE held while in E
      mc_start_e = 1;
      for (int k = 0; k < 8; k++) begin
         sample($sformatf("mc_c%0d", k));
         check($sformatf("mc_stall_c%0d", k), 11'({sf[0], se[0], fm[0]}), (k % 4 == 3) ? 11'd0 : 11'd7);
         check($sformatf("mc_busy_c%0d", k), 11'(busy[0]), (k % 4 == 0) ? 11'd0 : 11'd1);
         check($sformatf("mc_lat1_c%0d", k), 11'({sf[2], busy[2]}), 11'd0);
         advance();
      end
      mc_start_e = 0;
      cycle("mc_idle");

      // Reset on BUSY cycle 2
      mc_start_e = 1;
      cycle("rb_c0");
      cycle("rb_c1");
      reset = 1;
      sample("rb_reset");
      check("rb_reset_zero", obs[0], 11'd0);
      advance();
      reset = 0; mc_start_e = 0;
      sample("rb_after");
      check("rb_after_zero", obs[0], 11'd0);
      advance();

      // RAW stall without forwarding; W match is not a hazard
      reg_write_e = 1; rd_e = 3; rs1_d = 3;
      sample("raw_e");
      check("raw_e_const", 11'({sf[1], sd[1], fe[1]}), 11'd7);
      advance();
      reg_write_e = 0; rd_e = 0; rd_w = 3; reg_write_w = 1;
      sample("raw_w");
      check("raw_w_const", obs[1], 11'd0);
      advance();
      clr();

      // Branch with load-use; load-use while BUSY
      pc_src_e = 1; result_src_e = 2'b01; rd_e = 9; rs1_d = 9;
      sample("br_lw");
      check("br_lw_const", 11'({sf[0], sd[0], fd[0], fe[0]}), 11'hF);
      advance();
      clr();
      mc_start_e = 1;
      cycle("bl_c0");
      result_src_e = 2'b01; rd_e = 9; rs1_d = 9;
      sample("bl_c1");
      check("bl_flush_e_const", 11'({fe[0], sf[0]}), 11'd1);
      advance();
      cycle("bl_c2");
      cycle("bl_c3");
      clr();

      // Random stimulus against the model
      for (int n = 0; n < 800; n++) begin
         reset        = ($urandom_range(0, 59) == 0);
         rs1_d        = 5'($urandom_range(0, 3));
         rs2_d        = 5'($urandom_range(0, 3));
         rs1_e        = 5'($urandom_range(0, 3));
         rs2_e        = 5'($urandom_range(0, 3));
         rd_e         = 5'($urandom_range(0, 3));
         rd_m         = 5'($urandom_range(0, 3));
         rd_w         = 5'($urandom_range(0, 3));
         reg_write_e  = 1'($urandom_range(0, 1));
         reg_write_m  = 1'($urandom_range(0, 1));
         reg_write_w  = 1'($urandom_range(0, 1));
         result_src_e = 2'($urandom_range(0, 3));
         mc_start_e   = (rem[0] > 0) ? 1'b1 : 1'($urandom_range(0, 5) == 0);
         pc_src_e     = !mc_start_e && ($urandom_range(0, 5) == 0);
         cycle($sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
